mac_acc4: RTL and testbench

MAC_ACC4 -- requirements
Module: mac_acc4

---
 rtl/mac_acc4_if.sv | 15 +
 rtl/mac_acc4.sv | 54 +++++
 tb/tb_mac_acc4.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mac_acc4_if.sv
// mac_acc4_if: job start, operand-pair and result handshake bundle for mac_acc4.
interface mac_acc4_if #(parameter int ACC_W = 12);
    logic             start;
    logic [3:0]       len;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc;
    logic             busy;
    modport master(output start, len, a, b, in_valid, out_ready, input in_ready, out_valid, acc, busy);
    modport slave(input start, len, a, b, in_valid, out_ready, output in_ready, out_valid, acc, busy);
endinterface

// File: rtl/mac_acc4.sv
// mac_acc4: sums len products of 4-bit unsigned pairs through a one-stage product register.
module mac_acc4 #(parameter int ACC_W = 12) (
    input logic      clk,
    input logic      rst,
    mac_acc4_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;
    state_t           state, nxt;
    logic [3:0]       cnt;
    logic [7:0]       prod;
    logic             pv;
    logic [ACC_W-1:0] acc_q;
    logic             take;
    logic             go;
    assign take = bus.in_valid && state == ACC;
    assign go   = bus.start && state == IDLE;
    assign bus.acc = acc_q;
    always_comb begin
        nxt           = state;
        bus.in_ready  = state == ACC;
        bus.out_valid = state == DONE;
        bus.busy      = state != IDLE;
        if (go)
            nxt = bus.len == 4'd0 ? DONE : ACC;
        else if (take && cnt == 4'd1)
            nxt = DRAIN;
        else if (state == DRAIN)
            nxt = DONE;
        else if (state == DONE && bus.out_ready)
            nxt = IDLE;
    end
    // The final product lands in acc on the DRAIN edge, so DONE always sees the full sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            prod  <= '0;
            pv    <= 1'b0;
            acc_q <= '0;
        end else begin
            state <= nxt;
            pv    <= take;
            if (take) begin
                prod <= {4'b0, bus.a} * {4'b0, bus.b};
                cnt  <= cnt - 4'd1;
            end
            if (go) begin
                acc_q <= '0;
                cnt   <= bus.len;
            end else if (pv)
                acc_q <= acc_q + ACC_W'(prod);
        end
    end
endmodule

// File: tb/tb_mac_acc4.sv
// tb_mac_acc4: randomized and directed jobs checked every cycle against a job-level model.
module tb_mac_acc4;
    localparam int P_IDLE = 0, P_COL = 1, P_DRAIN = 2, P_DONE = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0, n_bad = 0;
    int   m_ph = P_IDLE, m_left = 0, m_sum = 0, m_res = 0, m_nacc = 0;
    bit   m_ok = 1'b0;
    int   ja[16], jb[16];

    mac_acc4_if #(.ACC_W(12)) ifc();
    mac_acc4 #(.ACC_W(12)) dut(.clk(clk), .rst(rst), .bus(ifc.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Job-level reference: the sum is known as soon as each pair is taken; it is published
    // as the result one edge after the last pair, and the job is visible as done then.
    always @(posedge clk) begin
        if (rst) begin
            m_ph  <= P_IDLE;
            m_res <= 0;
            m_ok  <= 1'b1;
        end else if (m_ph == P_IDLE) begin
            if (ifc.start) begin
                m_sum  <= 0;
                m_res  <= 0;
                m_left <= int'(ifc.len);
                m_ph   <= ifc.len == 0 ? P_DONE : P_COL;
            end
        end else if (m_ph == P_COL) begin
            if (ifc.in_valid) begin
                m_sum  <= m_sum + int'(ifc.a) * int'(ifc.b);
                m_left <= m_left - 1;
                m_nacc <= m_nacc + 1;
                if (m_left == 1) m_ph <= P_DRAIN;
            end
        end else if (m_ph == P_DRAIN) begin
            m_res <= m_sum;
            m_ph  <= P_DONE;
        end else if (ifc.out_ready)
            m_ph <= P_IDLE;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("in_ready", int'(ifc.in_ready), int'(m_ph == P_COL));
            chk("out_valid", int'(ifc.out_valid), int'(m_ph == P_DONE));
            chk("busy", int'(ifc.busy), int'(m_ph != P_IDLE));
            if (m_ph == P_IDLE || m_ph == P_DONE) chk("acc", int'(ifc.acc), m_res);
        end
    end

    // Called at a negedge; returns at a negedge with the job fully handed back to IDLE.
    task automatic run_job(input int l, input int gmin, input int gmax, input int hold, input int exp_acc, input string nm);
        int n0, lat, w, got, sum;
        n0  = m_nacc;
        sum = 0;
        ifc.start = 1'b1;
        ifc.len   = 4'(l);
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < l; i++) begin
            repeat ($urandom_range(gmax, gmin)) begin
                ifc.in_valid = 1'b0;
                ifc.start    = 1'b1;
                ifc.a        = 4'($urandom);
                ifc.b        = 4'($urandom);
                @(negedge clk);
            end
            w = 0;
            while (!ifc.in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) chk({nm, "_ready_timeout"}, w, 0);
            ifc.start    = 1'b0;
            ifc.in_valid = 1'b1;
            ifc.a        = 4'(ja[i]);
            ifc.b        = 4'(jb[i]);
            sum += ja[i] * jb[i];
            @(negedge clk);
            ifc.in_valid = 1'b0;
        end
        if (l == 0)
            chk({nm, "_len0_done"}, int'(ifc.out_valid), 1);
        else begin
            lat = 1;
            while (!ifc.out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk({nm, "_latency"}, lat, 2);
        end
        got = int'(ifc.acc);
        chk({nm, "_sum"}, got, sum);
        chk({nm, "_accepts"}, m_nacc - n0, l);
        if (exp_acc >= 0) begin
            chk(nm, got, exp_acc);
            chk({nm, "_model"}, m_res, exp_acc);
        end
        repeat (hold) begin
            ifc.start     = 1'b1;
            ifc.in_valid  = 1'($urandom);
            ifc.out_ready = 1'b0;
            @(negedge clk);
            chk({nm, "_hold_acc"}, int'(ifc.acc), got);
            chk({nm, "_hold_ov"}, int'(ifc.out_valid), 1);
        end
        ifc.start     = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        chk({nm, "_release_ov"}, int'(ifc.out_valid), 0);
        chk({nm, "_release_busy"}, int'(ifc.busy), 0);
        chk({nm, "_idle_acc"}, int'(ifc.acc), got);
    endtask

    initial begin
        ifc.start = 1'b0; ifc.len = '0; ifc.a = '0; ifc.b = '0;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_acc", int'(ifc.acc), 0);
        chk("reset_busy", int'(ifc.busy), 0);
        rst = 1'b0;
        ja[0] = 15; jb[0] = 15;
        run_job(1, 0, 0, 0, 225, "one_pair");
        for (int i = 0; i < 15; i++) begin ja[i] = 15; jb[i] = 15; end
        run_job(15, 0, 0, 0, 3375, "max_len");
        ja[0] = 3; jb[0] = 4; ja[1] = 0; jb[1] = 9; ja[2] = 7; jb[2] = 2;
        run_job(3, 2, 2, 1, 26, "gapped");
        run_job(0, 0, 0, 2, 0, "len0");
        ja[0] = 5; jb[0] = 6; ja[1] = 1; jb[1] = 1;
        run_job(2, 1, 2, 5, 31, "stall");
        ifc.start = 1'b1; ifc.len = 4'd4;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ifc.in_valid = 1'b1; ifc.a = 4'd9; ifc.b = 4'd9;
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(ifc.in_ready), 0);
        chk("rst_out_valid", int'(ifc.out_valid), 0);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_acc", int'(ifc.acc), 0);
        rst = 1'b0;
        ja[0] = 2; jb[0] = 3;
        run_job(1, 0, 0, 0, 6, "after_rst");
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < 16; i++) begin
                ja[i] = $urandom_range(15, 0);
                jb[i] = $urandom_range(15, 0);
            end
            run_job($urandom_range(15, 0), 0, 2, $urandom_range(3, 0), -1, "rand");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
